uart_tx_fifo: RTL and testbench

- UART 8N1 transmitter with an 8-entry write-side FIFO; drives the serial line data_out.
- Transmit-side companion of the UART receive path in ctrl_top.
- Frame format and bit timing match the existing receiver: 9600 baud at 50 MHz, 5208 cycles per bit.
- Upstream logic pushes bytes with a write strobe; the block serialises them LSB first, back to back, without software pacing.

---
 rtl/uart_tx_fifo_if.sv | 25 ++
 rtl/uart_tx_fifo.sv | 142 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Byte-write and status bundle between upstream logic and the UART transmitter.
// The serial line is carried here too so the transmitter has one bus port.
interface uart_tx_fifo_if #(
    parameter int unsigned ADDR_W = 3
) ();
    logic [7:0]      tx_data;
    logic            tx_wr;
    logic            fifo_full;
    logic            fifo_empty;
    logic [ADDR_W:0] fifo_cnt;
    logic            ovf_err;
    logic            tx_busy;
    logic            tx_done;
    logic            data_out;

    modport master (
        output tx_data, tx_wr,
        input  fifo_full, fifo_empty, fifo_cnt, ovf_err, tx_busy, tx_done, data_out
    );

    modport slave (
        input  tx_data, tx_wr,
        output fifo_full, fifo_empty, fifo_cnt, ovf_err, tx_busy, tx_done, data_out
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a small write-side FIFO; frames go out LSB first,
// back to back, with a two-cycle idle-high gap (IDLE, LOAD) between frames.
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_W     = 3
) (
    input logic           s_clk,
    input logic           s_rst_n,
    uart_tx_fifo_if.slave bus
);
    localparam int unsigned BAUD_CNT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W    = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;

    localparam logic [CNT_W-1:0]  BaudLast = CNT_W'(BAUD_CNT - 1);
    localparam logic [ADDR_W:0]   DepthVal = (ADDR_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]   CntOne   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PtrOne   = ADDR_W'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SEND = 2'd2;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              ovf_q, ovf_d;

    logic [1:0]        state_q, state_d;
    logic [9:0]        frame_q, frame_d;
    logic [3:0]        bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]  baud_cnt_q, baud_cnt_d;
    logic              data_out_q, data_out_d;

    logic              wr_en;
    logic              pop;
    logic              frame_end;

    always_comb begin
        // Acceptance uses the registered full flag, so a pop in the same cycle frees no room.
        wr_en     = bus.tx_wr && !full_q;
        pop       = (state_q == IDLE) && !empty_q;
        frame_end = (state_q == SEND) && (bit_idx_q == 4'd9) && (baud_cnt_q == BaudLast);

        wr_ptr_d = wr_en ? (wr_ptr_q + PtrOne) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q + PtrOne) : rd_ptr_q;

        unique case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + CntOne;
            2'b01:   cnt_d = cnt_q - CntOne;
            default: cnt_d = cnt_q;
        endcase

        full_d  = (cnt_d == DepthVal);
        empty_d = (cnt_d == '0);
        ovf_d   = ovf_q | (bus.tx_wr & full_q);
    end

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        bit_idx_d  = bit_idx_q;
        baud_cnt_d = baud_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // The read pointer already advanced on the pop; the byte sits one slot back.
                frame_d    = {1'b1, mem_q[rd_ptr_q - PtrOne], 1'b0};
                bit_idx_d  = 4'd0;
                baud_cnt_d = '0;
                state_d    = SEND;
            end
            SEND: begin
                if (baud_cnt_q == BaudLast) begin
                    baud_cnt_d = '0;
                    if (frame_end) begin
                        state_d = IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered line driven from next-state values so the start bit follows LOAD directly.
        data_out_d = (state_d == SEND) ? frame_d[bit_idx_d] : 1'b1;
    end

    always_ff @(posedge s_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= bus.tx_data;
        end
    end

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ovf_q      <= 1'b0;
            state_q    <= IDLE;
            frame_q    <= '1;
            bit_idx_q  <= '0;
            baud_cnt_q <= '0;
            data_out_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            frame_q    <= frame_d;
            bit_idx_q  <= bit_idx_d;
            baud_cnt_q <= baud_cnt_d;
            data_out_q <= data_out_d;
        end
    end

    assign bus.fifo_full  = full_q;
    assign bus.fifo_empty = empty_q;
    assign bus.fifo_cnt   = cnt_q;
    assign bus.ovf_err    = ovf_q;
    assign bus.tx_busy    = (state_q != IDLE);
    assign bus.tx_done    = frame_end;
    assign bus.data_out   = data_out_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and randomized checks of uart_tx_fifo against line-level expectations
// and a mid-bit sampling UART receiver model.
module tb_uart_tx_fifo;
    localparam int unsigned CLK_HZ = 50_000_000;
    localparam int unsigned BAUD_HZ = 5_000_000;
    localparam int BC = CLK_HZ / BAUD_HZ;   // cycles per bit on the line
    localparam int FRAME = 10 * BC;

    logic s_clk;
    logic s_rst_n;

    uart_tx_fifo_if #(.ADDR_W(3)) bus ();

    uart_tx_fifo #(
        .CLK_FREQ  (CLK_HZ),
        .BAUD      (BAUD_HZ),
        .FIFO_DEPTH(8),
        .ADDR_W    (3)
    ) dut (
        .s_clk  (s_clk),
        .s_rst_n(s_rst_n),
        .bus    (bus)
    );

    initial s_clk = 1'b0;
    always #5 s_clk = ~s_clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic [8:0] rx_q[$];   // {stop bit, data byte} as seen on the line
    logic [7:0] exp_q[$];

    // Receiver model: detect the start edge, then sample each bit in its middle.
    bit         mon_act = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_sh = '0;
    always @(negedge s_clk) begin
        if (!s_rst_n) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (bus.data_out === 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt >= BC && mon_cnt < 9 * BC && (mon_cnt % BC) == BC / 2) begin
                mon_sh[mon_cnt / BC - 1] = bus.data_out;
            end
            if (mon_cnt == 9 * BC + BC / 2) begin
                rx_q.push_back({bus.data_out, mon_sh});
                mon_act = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout, required $finish before 1000000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge s_clk);
        #1;
    endtask

    function automatic logic line_bit(input logic [7:0] b, input int c);
        int k;
        k = c / BC;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k - 1];
    endfunction

    // Called on the first start-bit cycle; returns on the cycle after the stop bit.
    task automatic expect_frame(input logic [7:0] b);
        for (int c = 0; c < FRAME; c++) begin
            chk($sformatf("line_%02h_c%0d", b, c), bus.data_out, line_bit(b, c));
            chk($sformatf("done_%02h_c%0d", b, c), bus.tx_done, (c == FRAME - 1));
            chk($sformatf("busy_%02h_c%0d", b, c), bus.tx_busy, 1);
            step();
        end
    endtask

    task automatic expect_gap(input int idle_cnt, input int load_cnt);
        chk("gap_idle_line", bus.data_out, 1);
        chk("gap_idle_busy", bus.tx_busy, 0);
        chk("gap_idle_cnt", bus.fifo_cnt, idle_cnt);
        step();
        chk("gap_load_line", bus.data_out, 1);
        chk("gap_load_busy", bus.tx_busy, 1);
        chk("gap_load_cnt", bus.fifo_cnt, load_cnt);
        step();
    endtask

    task automatic wait_rx(input int n, input int limit);
        int w = 0;
        while (rx_q.size() < n && w < limit) begin
            step();
            w++;
        end
        chk("rx_count", rx_q.size(), n);
    endtask

    task automatic wait_idle(input int limit);
        int w = 0;
        while ((bus.fifo_empty !== 1'b1 || bus.tx_busy !== 1'b0) && w < limit) begin
            step();
            w++;
        end
        chk("idle_reached", {bus.fifo_empty, bus.tx_busy}, 2'b10);
    endtask

    task automatic compare_rx();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) begin
                chk($sformatf("rx_byte%0d", i), rx_q[i], {1'b1, exp_q[i]});
            end
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        s_rst_n = 1'b0;
        bus.tx_wr = 1'b0;
        repeat (2) step();
        s_rst_n = 1'b1;
        step();
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int bad;
        int written;
        int w;
        logic [7:0] b;

        s_rst_n = 1'b1;
        bus.tx_wr = 1'b0;
        bus.tx_data = '0;
        #3;
        s_rst_n = 1'b0;
        #1;
        chk("rst_line", bus.data_out, 1);
        chk("rst_busy", bus.tx_busy, 0);
        chk("rst_done", bus.tx_done, 0);
        chk("rst_ovf", bus.ovf_err, 0);
        chk("rst_cnt", bus.fifo_cnt, 0);
        chk("rst_empty", bus.fifo_empty, 1);
        chk("rst_full", bus.fifo_full, 0);
        do_reset();

        // Single byte: write at N, start bit from N+3.
        bus.tx_data = 8'h55;
        bus.tx_wr = 1'b1;
        step();
        bus.tx_wr = 1'b0;
        chk("t1_empty_n1", bus.fifo_empty, 0);
        chk("t1_cnt_n1", bus.fifo_cnt, 1);
        chk("t1_busy_n1", bus.tx_busy, 0);
        chk("t1_line_n1", bus.data_out, 1);
        step();
        chk("t1_busy_n2", bus.tx_busy, 1);
        chk("t1_line_n2", bus.data_out, 1);
        chk("t1_cnt_n2", bus.fifo_cnt, 0);
        step();
        exp_q.push_back(8'h55);
        expect_frame(8'h55);
        chk("t1_busy_after", bus.tx_busy, 0);
        chk("t1_done_after", bus.tx_done, 0);
        chk("t1_line_after", bus.data_out, 1);
        wait_rx(1, 10);
        compare_rx();

        // Three consecutive writes; the second coincides with the first pop.
        bus.tx_data = 8'hA5;
        bus.tx_wr = 1'b1;
        step();
        chk("t2_cnt_a", bus.fifo_cnt, 1);
        bus.tx_data = 8'h3C;
        step();
        chk("t2_cnt_b", bus.fifo_cnt, 1);
        bus.tx_data = 8'hFF;
        step();
        bus.tx_wr = 1'b0;
        chk("t2_cnt_c", bus.fifo_cnt, 2);
        expect_frame(8'hA5);
        expect_gap(2, 1);
        expect_frame(8'h3C);
        expect_gap(1, 0);
        expect_frame(8'hFF);
        chk("t2_busy_end", bus.tx_busy, 0);
        chk("t2_empty_end", bus.fifo_empty, 1);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hFF);
        wait_rx(3, 10);
        compare_rx();

        // Ten writes while idle: only the last is dropped.
        for (int i = 0; i < 10; i++) begin
            bus.tx_data = 8'(i);
            bus.tx_wr = 1'b1;
            if (i == 8) chk("t3_full_before", bus.fifo_full, 0);
            if (i == 9) begin
                chk("t3_full", bus.fifo_full, 1);
                chk("t3_ovf_before", bus.ovf_err, 0);
            end
            if (i < 9) exp_q.push_back(8'(i));
            step();
        end
        bus.tx_wr = 1'b0;
        chk("t3_ovf", bus.ovf_err, 1);
        chk("t3_cnt", bus.fifo_cnt, 8);
        wait_rx(9, 9 * (FRAME + 2) + 20);
        wait_idle(FRAME + 20);
        repeat (FRAME) step();
        chk("t3_rx_total", rx_q.size(), 9);
        chk("t3_ovf_sticky", bus.ovf_err, 1);
        compare_rx();
        do_reset();
        chk("t3_ovf_cleared", bus.ovf_err, 0);

        // Reset in the middle of d3 aborts the frame and flushes the queue.
        bus.tx_data = 8'h81;
        bus.tx_wr = 1'b1;
        step();
        bus.tx_data = 8'h42;
        step();
        bus.tx_wr = 1'b0;
        step();
        repeat (4 * BC + BC / 2) step();
        chk("t4_line_d3", bus.data_out, 0);
        chk("t4_cnt_pre", bus.fifo_cnt, 1);
        #2;
        s_rst_n = 1'b0;
        #1;
        chk("t4_line_rst", bus.data_out, 1);
        chk("t4_cnt_rst", bus.fifo_cnt, 0);
        chk("t4_busy_rst", bus.tx_busy, 0);
        chk("t4_done_rst", bus.tx_done, 0);
        chk("t4_empty_rst", bus.fifo_empty, 1);
        step();
        step();
        s_rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 15 * BC; c++) begin
            step();
            if (bus.data_out !== 1'b1 || bus.tx_done !== 1'b0) bad++;
        end
        chk("t4_idle_after", bad, 0);
        chk("t4_rx_none", rx_q.size(), 0);
        chk("t4_busy_after", bus.tx_busy, 0);
        do_reset();

        // Full FIFO during SEND, write held across the pop cycle.
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            bus.tx_data = b;
            bus.tx_wr = 1'b1;
            step();
        end
        bus.tx_wr = 1'b0;
        chk("t5_cnt_full", bus.fifo_cnt, 8);
        chk("t5_full", bus.fifo_full, 1);
        chk("t5_ovf0", bus.ovf_err, 0);
        chk("t5_busy", bus.tx_busy, 1);
        w = 0;
        while (bus.tx_done !== 1'b1 && w < FRAME + 10) begin
            step();
            w++;
        end
        chk("t5_done_seen", bus.tx_done, 1);
        step();
        bus.tx_data = 8'hD0;
        bus.tx_wr = 1'b1;
        chk("t5_pop_busy", bus.tx_busy, 0);
        chk("t5_pop_full", bus.fifo_full, 1);
        chk("t5_pop_cnt", bus.fifo_cnt, 8);
        step();
        chk("t5_load_full", bus.fifo_full, 0);
        chk("t5_load_cnt", bus.fifo_cnt, 7);
        chk("t5_load_ovf", bus.ovf_err, 1);
        bus.tx_data = 8'hD1;
        exp_q.push_back(8'hD1);
        step();
        bus.tx_wr = 1'b0;
        chk("t5_refill_cnt", bus.fifo_cnt, 8);
        chk("t5_refill_full", bus.fifo_full, 1);
        wait_rx(10, 10 * (FRAME + 2) + 20);
        compare_rx();
        wait_idle(FRAME + 20);
        do_reset();

        // Stream 20 random bytes, writing only when not full, with random gaps.
        written = 0;
        w = 0;
        while (written < 20 && w < 5000) begin
            if (bus.fifo_full === 1'b0 && $urandom_range(0, 3) != 0) begin
                b = 8'($urandom);
                exp_q.push_back(b);
                bus.tx_data = b;
                bus.tx_wr = 1'b1;
                written++;
            end else begin
                bus.tx_wr = 1'b0;
            end
            step();
            w++;
        end
        bus.tx_wr = 1'b0;
        chk("t6_written", written, 20);
        wait_rx(20, 20 * (FRAME + 2) + 50);
        chk("t6_ovf", bus.ovf_err, 0);
        compare_rx();
        wait_idle(FRAME + 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
